mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the execute stage, owning the HI/LO registers.
//  The E stage issues mult/div/mthi/mtlo requests and mfhi/mflo reads.
//  The unit answers with a busy flag, which the hazard unit uses to stall D.
//  It also supplies HI/LO read data back to the E result mux.
// PARAMETERS
//  MUL_LAT  5   cycles busy is held after accepting MULT/MULTU
//  DIV_LAT  10  cycles busy is held after accepting DIV/DIVU
// PORTS
//  clk        in   1   clock; all state changes on posedge
//  reset      in   1   asynchronous, active-low (0 = reset), one clock domain
//  E_start    in   1   1-cycle pulse: op in E is MULT/MULTU/DIV/DIVU
//  E_op       in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved (=NONE)
//  E_inA      in   32  forwarded rs value
//  E_inB      in   32  forwarded rt value
//  E_rdsel    in   1   0 = read LO, 1 = read HI
//  E_busy     out  1   operation in flight
//  E_HILO_out out  32  HI or LO per E_rdsel (combinational from registers)
// BEHAVIOUR
//  Reset (async, reset==0):
//   - HI=LO=0, E_busy=0, counter=0, state IDLE.
//   - Any in-flight result is discarded; no HI/LO update after reset is released.
//  States: IDLE, RUN. Counter is 4 bits and counts down.
//  IDLE + E_start sampled at edge T (op 1..4):
//   - Latch operands and op, load counter with LAT (MUL_LAT for 1/2, DIV_LAT for 3/4), go RUN.
//   - E_busy=1 in cycles T+1 .. T+LAT.
//  RUN, every edge:
//   - counter-1.
//   - At the edge where counter goes 1->0: commit HI/LO, go IDLE.
//   - New HI/LO and E_busy=0 are visible in cycle T+LAT+1.
//  E_start during RUN is ignored; the hazard unit guarantees it never occurs.
//  MTHI/MTLO (op 5/6, E_start=0):
//   - Accepted only when IDLE; write E_inA into HI/LO at the edge; no busy.
//   - Ignored in RUN (illegal by hazard contract; HI/LO must not change).
//  E_HILO_out:
//   - Reflects the register value only; no internal bypass.
//   - MFHI in E the cycle after an MTHI sees the new value via the register.
//  Arithmetic (operands as latched at accept):
//   - MULT:  {HI,LO} = signed 64-bit product.
//   - MULTU: {HI,LO} = unsigned 64-bit product.
//   - DIV:   LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
//   - DIVU:  LO = unsigned quotient; HI = unsigned remainder.
//   - Divide by zero (any sign): HI and LO unchanged; busy timing identical to a normal DIV.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
//  Implementation choice is free (operator result held in shadow regs, or iterative),
//  provided cycle timing is exactly as above.
//  Simultaneous events:
//   - E_start and op 5/6 are mutually exclusive by decode.
//   - If reset and the commit edge coincide, reset wins.
// TESTING
//  1. reset=0 for 2 cycles, then release -> HI=LO=0, E_busy=0; E_rdsel=1 gives E_HILO_out=0.
//  2. MULT 0xFFFFFFFE * 3 at edge T:
//     - E_busy=1 for exactly 5 cycles.
//     - Cycle T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//     - MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  3. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles;
//     DIVU 7 / 0 -> HI/LO unchanged, still 10 busy cycles.
//  4. MTHI 0x12345678 then E_rdsel=1 next cycle -> E_HILO_out=0x12345678;
//     MTLO issued while busy -> LO unchanged after commit except by the mult/div result.
//  5. MULT accepted, reset pulsed low at cycle T+3 -> E_busy=0 immediately, HI=LO=0,
//     no update at T+6.
//  6. Back-to-back: DIV accepted on the first cycle E_busy=0 after a prior MULT
//     -> MULT result visible, then DIV commits 10 cycles later.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the execute stage.
// Owns the HI/LO registers, raises E_busy while a MULT/DIV is in flight,
// and serves HI or LO back to the E result mux straight from the registers.
module mult_div_unit #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_start,
  input  logic [2:0]  E_op,
  input  logic [31:0] E_inA,
  input  logic [31:0] E_inB,
  input  logic        E_rdsel,
  output logic        E_busy,
  output logic [31:0] E_HILO_out
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic [3:0]                 cnt;
  logic [DATA_W-1:0]          hi, lo;
  logic signed [DATA_W-1:0]   a_q, b_q;
  logic [2:0]                 op_q;

  logic                       accept;
  logic                       is_div_op;
  logic [2*DATA_W-1:0]        prod_s, prod_u, div_res;
  logic [DATA_W-1:0]          res_hi, res_lo;
  logic                       res_we;

  // Divide on magnitudes so the INT_MIN / -1 case wraps cleanly; returns {rem, quo}.
  // A zero divisor returns zero here; the caller suppresses the commit.
  function automatic logic [2*DATA_W-1:0] div_fn(input logic signed [DATA_W-1:0] a,
                                                 input logic signed [DATA_W-1:0] b,
                                                 input logic sgn);
    logic [DATA_W-1:0] ua, ub, uq, ur, q, r;
    ua = (sgn && a[DATA_W-1]) ? DATA_W'(-a) : DATA_W'(a);
    ub = (sgn && b[DATA_W-1]) ? DATA_W'(-b) : DATA_W'(b);
    uq = (ub == '0) ? '0 : ua / ub;
    ur = (ub == '0) ? '0 : ua % ub;
    q  = (sgn && (a[DATA_W-1] ^ b[DATA_W-1])) ? -uq : uq;
    r  = (sgn && a[DATA_W-1]) ? -ur : ur;
    return {r, q};
  endfunction

  assign is_div_op = (E_op == OP_DIV) || (E_op == OP_DIVU);
  assign accept    = (state == IDLE) && E_start &&
                     ((E_op == OP_MULT) || (E_op == OP_MULTU) || is_div_op);

  // Capture operands and op on accept; pure data, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= E_inA;
      b_q  <= E_inB;
      op_q <= E_op;
    end
  end

  // Result selection from the latched operands, ready for the commit edge.
  always_comb begin
    prod_s  = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
    prod_u  = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    div_res = div_fn(a_q, b_q, op_q == OP_DIV);
    res_hi  = hi;
    res_lo  = lo;
    res_we  = 1'b0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[2*DATA_W-1:DATA_W]; res_lo = prod_s[DATA_W-1:0]; res_we = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[2*DATA_W-1:DATA_W]; res_lo = prod_u[DATA_W-1:0]; res_we = 1'b1; end
      OP_DIV, OP_DIVU: begin
        res_hi = div_res[2*DATA_W-1:DATA_W];
        res_lo = div_res[DATA_W-1:0];
        res_we = (b_q != '0);
      end
      default: res_we = 1'b0;
    endcase
  end

  // Control FSM: accept, count down the latency, commit HI/LO; MTHI/MTLO only when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      E_busy <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= RUN;
            cnt    <= is_div_op ? 4'(DIV_LAT) : 4'(MUL_LAT);
            E_busy <= 1'b1;
          end else if (E_op == OP_MTHI) begin
            hi <= E_inA;
          end else if (E_op == OP_MTLO) begin
            lo <= E_inA;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= IDLE;
            E_busy <= 1'b0;
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign E_HILO_out = E_rdsel ? hi : lo;

endmodule
